// File: rtl/puf_response_sequencer.sv
// RO-PUF response sequencer: one challenge evaluation per bit, MSB-first word out over valid/ready.
// Optional WAIT timeout with sticky err enabled by defining PUF_SEQ_TIMEOUT_EN.
module puf_response_sequencer #(
    parameter int unsigned N_BITS      = 8,
    parameter int unsigned CHAL_W      = 4,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_base,
    output logic              ro_en,
    output logic [CHAL_W-1:0] challenge,
    input  logic              cmp_valid,
    input  logic              cmp_bit,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [N_BITS-1:0] resp_data,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(N_BITS);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

    if (N_BITS < 2 || N_BITS > 32 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("puf_response_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENABLE = 2'd1,
        WAIT   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [SET_W-1:0] settle_cnt;
    logic             timeout_hit;

`ifdef PUF_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    // A real comparator strobe on the expiry cycle wins over the timeout.
    assign timeout_hit = !cmp_valid && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign err         = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                err_q <= 1'b0;
            end else if (state == WAIT && timeout_hit) begin
                err_q <= 1'b1;
            end
            if (state == WAIT && !cmp_valid && !timeout_hit) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Main sequencer; resp_data doubles as the response shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ro_en      <= 1'b0;
            challenge  <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            bit_idx    <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ENABLE;
                        challenge  <= chal_base;
                        bit_idx    <= '0;
                        settle_cnt <= '0;
                        resp_data  <= '0;
                        ro_en      <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ENABLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        settle_cnt <= '0;
                        ro_en      <= 1'b0;
                        state      <= WAIT;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                WAIT: begin
                    if (cmp_valid || timeout_hit) begin
                        // On timeout cmp_valid is low, so a 0 is shifted in.
                        resp_data <= {resp_data[N_BITS-2:0], cmp_valid & cmp_bit};
                        if (bit_idx == IDX_W'(N_BITS - 1)) begin
                            resp_valid <= 1'b1;
                            state      <= OUT;
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            challenge <= challenge + CHAL_W'(1);
                            ro_en     <= 1'b1;
                            state     <= ENABLE;
                        end
                    end
                end
                OUT: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Directed, table-driven bench for puf_response_sequencer; comparator is emulated per WAIT window.
module tb_puf_response_sequencer;

    localparam int unsigned N_BITS     = 8;
    localparam int unsigned CHAL_W     = 4;
    localparam int unsigned SETTLE_CYC = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CHAL_W-1:0] chal_base;
    logic              ro_en;
    logic [CHAL_W-1:0] challenge;
    logic              cmp_valid;
    logic              cmp_bit;
    logic              busy;
    logic              resp_valid;
    logic              resp_ready;
    logic [N_BITS-1:0] resp_data;
    logic              err;

    always #5 clk = ~clk;

    puf_response_sequencer #(
        .N_BITS(N_BITS), .CHAL_W(CHAL_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .chal_base(chal_base),
        .ro_en(ro_en), .challenge(challenge), .cmp_valid(cmp_valid), .cmp_bit(cmp_bit),
        .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .err(err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [CHAL_W-1:0] base;
        logic [N_BITS-1:0] bits;       // comparator results, first one in MSB
        logic [N_BITS-1:0] exp_data;
        logic [CHAL_W-1:0] last_chal;
        logic              noise;      // stray cmp_valid/start during ENABLE
        logic              ready_early;
        int                hold;       // cycles resp_ready is held low in OUT
        logic              start_on_done;
    } vec_t;

    vec_t vecs[6];

    // Run one evaluation; the bench answers each WAIT on its first cycle unless stalled.
    task automatic run(input vec_t v, input int stall_bit, input int stall_cycles,
                       input int exp_lat, input int exp_wait, input logic exp_err);
        int cyc, n_pulse, plen, wlen, max_wait, bad_width, bad_chal, stable_bad;
        logic [CHAL_W-1:0] last_seen;
        logic [N_BITS-1:0] word;
        start      = 1'b1;
        chal_base  = v.base;
        resp_ready = v.ready_early;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; n_pulse = 0; plen = 0; wlen = 0; max_wait = 0;
        bad_width = 0; bad_chal = 0; last_seen = '0;
        while (!resp_valid && cyc < 3000) begin
            cmp_valid = 1'b0;
            start     = 1'b0;
            if (ro_en) begin
                wlen = 0;
                if (plen == 0) begin
                    n_pulse++;
                    if (challenge != CHAL_W'(int'(v.base) + n_pulse - 1)) bad_chal++;
                    last_seen = challenge;
                end else if (challenge != last_seen) begin
                    bad_chal++;
                end
                plen++;
                if (v.noise && plen == 5) begin
                    cmp_valid = 1'b1;
                    cmp_bit   = 1'b1;
                    start     = 1'b1;
                    chal_base = ~v.base;
                end
            end else begin
                if (plen != 0 && plen != int'(SETTLE_CYC)) bad_width++;
                plen = 0;
                if (busy) begin
                    wlen++;
                    if (wlen > max_wait) max_wait = wlen;
                    if (!(n_pulse - 1 == stall_bit && wlen <= stall_cycles)) begin
                        cmp_valid = 1'b1;
                        cmp_bit   = v.bits[int'(N_BITS) - n_pulse];
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        cmp_valid = 1'b0;
        start     = 1'b0;
        chk("resp_valid_seen", 32'(resp_valid), 32'd1);
        chk("resp_data", 32'(resp_data), 32'(v.exp_data));
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("pulse_count", 32'(n_pulse), 32'(N_BITS));
        chk("ro_en_width", 32'(bad_width), 32'd0);
        chk("challenge_seq", 32'(bad_chal), 32'd0);
        chk("last_challenge", 32'(last_seen), 32'(v.last_chal));
        chk("max_wait", 32'(max_wait), 32'(exp_wait));
        chk("err", 32'(err), 32'(exp_err));
        word = resp_data;
        stable_bad = 0;
        if (!v.ready_early) begin
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                if (!resp_valid || resp_data != word || !busy) stable_bad++;
            end
            resp_ready = 1'b1;
        end
        if (v.start_on_done) begin
            start     = 1'b1;
            chal_base = v.base;
        end
        @(negedge clk);
        resp_ready = 1'b0;
        start      = 1'b0;
        chk("hold_stable", 32'(stable_bad), 32'd0);
        chk("valid_drop", 32'(resp_valid), 32'd0);
        chk("idle_after_out", 32'(busy), 32'd0);
        chk("data_kept", 32'(resp_data), 32'(v.exp_data));
        if (v.start_on_done) begin
            @(negedge clk);
            chk("start_on_done_ignored", 32'({busy, ro_en}), 32'd0);
        end
    endtask

    initial begin
        vec_t sv;
        int   stall_lat, stall_wait;
        logic stall_err;
        rst = 1'b1; start = 1'b0; chal_base = '0;
        cmp_valid = 1'b0; cmp_bit = 1'b0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({ro_en, busy, resp_valid, err}), 32'd0);
        chk("rst_challenge", 32'(challenge), 32'd0);
        chk("rst_data", 32'(resp_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'({busy, ro_en}), 32'd0);

        //         base   bits    exp     last   noise early hold done
        vecs[0] = '{4'd3,  8'hB2, 8'hB2, 4'd10, 1'b0, 1'b0, 20, 1'b0};
        vecs[1] = '{4'd14, 8'h5C, 8'h5C, 4'd5,  1'b0, 1'b0, 0,  1'b0};
        vecs[2] = '{4'd3,  8'hB2, 8'hB2, 4'd10, 1'b1, 1'b0, 2,  1'b1};
        vecs[3] = '{4'd0,  8'hFF, 8'hFF, 4'd7,  1'b0, 1'b1, 0,  1'b0};
        vecs[4] = '{4'd9,  8'h01, 8'h01, 4'd0,  1'b0, 1'b0, 1,  1'b0};
        vecs[5] = '{4'd15, 8'h80, 8'h80, 4'd6,  1'b1, 1'b1, 0,  1'b1};
        for (int i = 0; i < 6; i++) begin
            run(vecs[i], -1, 0, 137, 1, 1'b0);
        end

        // Asynchronous reset in the middle of the first ENABLE window.
        start = 1'b1; chal_base = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_ro_en", 32'(ro_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_outputs", 32'({ro_en, busy, resp_valid, err}), 32'd0);
        chk("midrun_rst_challenge", 32'(challenge), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_idle", 32'({ro_en, busy, resp_valid}), 32'd0);
        run(vecs[0], -1, 0, 137, 1, 1'b0);

        // Withhold the comparator on the third bit for 100 WAIT cycles.
        sv = '{4'd0, 8'hE7, 8'hE7, 4'd7, 1'b0, 1'b0, 0, 1'b0};
`ifdef PUF_SEQ_TIMEOUT_EN
        sv.exp_data = 8'hC7;
        stall_lat   = 200;
        stall_wait  = 64;
        stall_err   = 1'b1;
`else
        stall_lat   = 237;
        stall_wait  = 101;
        stall_err   = 1'b0;
`endif
        run(sv, 2, 100, stall_lat, stall_wait, stall_err);
        run(vecs[1], -1, 0, 137, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_response_sequencer.md
Name: puf_response_sequencer

Overview:
Controller that sequences one RO-PUF evaluation per response bit and assembles the bits MSB-first into an N_BITS response word. For each bit it:
- drives a challenge to the ring-oscillator pair mux;
- enables the oscillators for a fixed settle window;
- waits for the counter comparator's result bit;
- shifts that bit in.
It sits between the PUF ring-oscillator/comparator datapath and the response consumer (UART/readout), delivering the finished word over a valid/ready handshake.

Parameters:
N_BITS, 8, response word width = number of challenges evaluated per run (2..32)
CHAL_W, 4, challenge index width
SETTLE_CYC, 16, clk cycles ro_en is held high per challenge (>=1)
TIMEOUT_CYC, 64, cycles WAIT tolerates without cmp_valid (used only with PUF_SEQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse/level; begins a run when sampled high in IDLE
chal_base  input  CHAL_W  first challenge of run; sampled on accepted start
ro_en  output  1  enables ring oscillators/counters for the current challenge
challenge  output  CHAL_W  challenge index to RO mux; chal_base + bit_idx, modulo 2^CHAL_W
cmp_valid  input  1  comparator result valid strobe
cmp_bit  input  1  comparator result (1 = RO A faster)
busy  output  1  high in any state except IDLE
resp_valid  output  1  response word available
resp_ready  input  1  consumer accepts word
resp_data  output  N_BITS  assembled response, first-evaluated bit in MSB
err  output  1  sticky timeout flag (constant 0 without PUF_SEQ_TIMEOUT_EN)

Behaviour:
- Reset (async, rst=1): state=IDLE, ro_en=0, challenge=0, busy=0, resp_valid=0, resp_data=0, err=0, bit_idx=0, settle counter=0. Reset mid-run aborts immediately with no partial output.
- States: IDLE, ENABLE, WAIT, OUT.
- IDLE:
  - On start=1: latch chal_base, set bit_idx=0, err=0, go to ENABLE.
  - The shift register is cleared to 0 on an accepted start.
- ENABLE:
  - ro_en=1 for exactly SETTLE_CYC cycles; challenge is stable throughout.
  - Then ro_en=0 and go to WAIT.
- WAIT:
  - ro_en=0, challenge held.
  - On cmp_valid=1: shreg <= {shreg[N_BITS-2:0], cmp_bit}.
  - If bit_idx==N_BITS-1: go to OUT. Otherwise bit_idx++ and go to ENABLE with the next challenge.
- OUT:
  - resp_valid=1; resp_data=shreg, held stable until handshake.
  - On resp_ready=1: resp_valid deasserts the next cycle and the state returns to IDLE.
- Handshake timing:
  - resp_ready high before resp_valid has no effect.
  - resp_ready high in the first OUT cycle gives a one-cycle resp_valid pulse.
- Ignored inputs:
  - cmp_valid outside WAIT is ignored.
  - start outside IDLE is ignored (no queuing).
  - start in the same cycle OUT completes is ignored; a new run needs start in IDLE.
- Challenge wrap: chal_base=14, CHAL_W=4 produces challenges 14, 15, 0, 1, ...
- resp_data is only meaningful while resp_valid=1; it holds the last word until the next accepted start.
- Latency with cmp_valid asserted on the first WAIT cycle: start -> resp_valid = N_BITS*(SETTLE_CYC+1)+1 cycles (default 137).

Optional Feature:
PUF_SEQ_TIMEOUT_EN
- Defined:
  - WAIT counts cycles.
  - If TIMEOUT_CYC cycles elapse without cmp_valid: shift 0 for that bit, set err=1 (sticky until the next accepted start), advance as if the bit arrived.
  - cmp_valid on the same cycle as the timeout takes priority: the real bit is used and no error is flagged.
- Undefined: WAIT waits indefinitely; err tied 0; no timeout counter logic.

Test Plan:
- Reset mid-ENABLE (rst pulsed asynchronously between clock edges) -> all outputs 0, state IDLE, next start runs cleanly.
- start, chal_base=3, comparator returns bits 1,0,1,1,0,0,1,0 one cycle into each WAIT:
  - challenge steps 3..10;
  - each ro_en pulse is 16 cycles;
  - resp_data=8'hB2 with resp_valid at cycle 137.
- chal_base=14 -> challenge sequence 14, 15, 0, 1, 2, 3, 4, 5 (wrap check).
- resp_ready held 0 for 20 cycles in OUT -> resp_valid and resp_data stay constant; ready=1 -> IDLE next cycle, busy=0.
- cmp_valid pulses during ENABLE and start pulses mid-run -> ignored; the word is unchanged vs. a clean run.
- With PUF_SEQ_TIMEOUT_EN: withhold cmp_valid on bit 2 -> after 64 cycles bit shifts as 0, err=1, run completes. Without the macro: run stalls in WAIT, busy stays 1.
